cq_req_arbiter: RTL

//  Shares the single-port CQ offset allocator between RTC, RRC and EE requesters. Each requester has a

---
 rtl/cq_arb_pkg.sv | 42 ++++
 rtl/cq_rr_arbiter.sv | 33 +++
 rtl/cq_req_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cq_arb_pkg.sv
// ---------------------------------------------------------------------------
// cq_arb_pkg : requester ids, FSM encodings and helpers for cq_req_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cq_arb_pkg;

  localparam int c_num_req    = 3;
  localparam int c_size_width = 32;
  localparam int c_wdog_width = 16;

  typedef enum logic [1:0] {
    REQ_RTC = 2'd0,
    REQ_RRC = 2'd1,
    REQ_EE  = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic req_id_e next_id(input req_id_e id);
    case (id)
      REQ_RTC: return REQ_RRC;
      REQ_RRC: return REQ_EE;
      default: return REQ_RTC;
    endcase
  endfunction

  function automatic req_id_e onehot_to_id(input logic [c_num_req-1:0] oh);
    if (oh[1]) return REQ_RRC;
    if (oh[2]) return REQ_EE;
    return REQ_RTC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cq_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cq_rr_arbiter : 3-way rotating-priority arbiter, search starts after i_last
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cq_rr_arbiter
  import cq_arb_pkg::*;
(
  input  logic [c_num_req-1:0] i_req,
  input  req_id_e              i_last,
  output logic [c_num_req-1:0] o_grant
);

  req_id_e w_cand;
  logic    w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_cand  = i_last;
    for (int k = 0; k < c_num_req; k++) begin
      w_cand = next_id(w_cand);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cq_req_arbiter.sv
// ---------------------------------------------------------------------------
// cq_req_arbiter : shares the CQ offset allocator among RTC/RRC/EE requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cq_req_arbiter
  import cq_arb_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH    = 24,
  parameter int unsigned OFFSET_WIDTH   = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_rtc_req_valid,
  output logic                    o_rtc_req_ready,
  input  logic [INDEX_WIDTH-1:0]  iv_rtc_cq_index,
  input  logic [31:0]             iv_rtc_cq_size,
  output logic                    o_rtc_resp_valid,
  output logic [OFFSET_WIDTH-1:0] ov_rtc_cq_offset,

  input  logic                    i_rrc_req_valid,
  output logic                    o_rrc_req_ready,
  input  logic [INDEX_WIDTH-1:0]  iv_rrc_cq_index,
  input  logic [31:0]             iv_rrc_cq_size,
  output logic                    o_rrc_resp_valid,
  output logic [OFFSET_WIDTH-1:0] ov_rrc_cq_offset,

  input  logic                    i_ee_req_valid,
  output logic                    o_ee_req_ready,
  input  logic [INDEX_WIDTH-1:0]  iv_ee_cq_index,
  input  logic [31:0]             iv_ee_cq_size,
  output logic                    o_ee_resp_valid,
  output logic [OFFSET_WIDTH-1:0] ov_ee_cq_offset,

  input  logic                    i_cqm_init_finish,
  output logic                    o_cqm_req_valid,
  output logic [INDEX_WIDTH-1:0]  ov_cqm_cq_index,
  output logic [31:0]             ov_cqm_cq_size,
  input  logic                    i_cqm_resp_valid,
  input  logic [OFFSET_WIDTH-1:0] iv_cqm_cq_offset,

  output logic                    o_timeout_err,
  output logic                    o_busy
);

  // Last WAIT cycle before the watchdog forces a response.
  localparam logic [c_wdog_width-1:0] c_wdog_last = c_wdog_width'(TIMEOUT_CYCLES - 1);

  logic [c_num_req-1:0]    w_req_valid;
  logic [c_num_req-1:0]    w_grant;
  logic [c_num_req-1:0]    w_ready;
  logic                    w_hs;
  logic                    w_timeout;
  logic                    w_resp_pulse;
  req_id_e                 w_gid_new;
  logic [INDEX_WIDTH-1:0]  w_idx_sel;
  logic [31:0]             w_size_sel;
  arb_state_e              w_state_nxt;

  arb_state_e              r_state;
  req_id_e                 r_last;
  req_id_e                 r_gid;
  logic [INDEX_WIDTH-1:0]  r_idx;
  logic [31:0]             r_size;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic [c_wdog_width-1:0] r_wdog;
  logic                    r_err;

  assign w_req_valid = {i_ee_req_valid, i_rrc_req_valid, i_rtc_req_valid};

  cq_rr_arbiter u_rr_arbiter (
    .i_req   (w_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_ready   = (r_state == ST_IDLE && i_cqm_init_finish) ? w_grant : '0;
  assign w_hs      = |(w_ready & w_req_valid);
  assign w_gid_new = onehot_to_id(w_grant);

  always_comb begin
    w_idx_sel  = iv_rtc_cq_index;
    w_size_sel = iv_rtc_cq_size;
    case (w_gid_new)
      REQ_RRC: begin
        w_idx_sel  = iv_rrc_cq_index;
        w_size_sel = iv_rrc_cq_size;
      end
      REQ_EE: begin
        w_idx_sel  = iv_ee_cq_index;
        w_size_sel = iv_ee_cq_size;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_hs) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A response in the expiry cycle beats the watchdog.
        if (i_cqm_resp_valid) begin
          w_state_nxt = ST_RESP;
        end else if (r_wdog == c_wdog_last) begin
          w_state_nxt = ST_RESP;
          w_timeout   = 1'b1;
        end
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= REQ_EE;
      r_gid    <= REQ_RTC;
      r_idx    <= '0;
      r_size   <= '0;
      r_offset <= '0;
      r_wdog   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_gid  <= w_gid_new;
        r_last <= w_gid_new;
        r_idx  <= w_idx_sel;
        r_size <= w_size_sel;
      end
      if (r_state == ST_ISSUE) begin
        r_wdog <= '0;
      end
      if (r_state == ST_WAIT) begin
        if (i_cqm_resp_valid) begin
          r_offset <= iv_cqm_cq_offset;
        end else if (w_timeout) begin
          r_offset <= '0;
          r_err    <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end
    end
  end

  assign w_resp_pulse = (r_state == ST_RESP);

  assign o_rtc_req_ready  = w_ready[REQ_RTC];
  assign o_rrc_req_ready  = w_ready[REQ_RRC];
  assign o_ee_req_ready   = w_ready[REQ_EE];

  assign o_rtc_resp_valid = w_resp_pulse && (r_gid == REQ_RTC);
  assign o_rrc_resp_valid = w_resp_pulse && (r_gid == REQ_RRC);
  assign o_ee_resp_valid  = w_resp_pulse && (r_gid == REQ_EE);

  assign ov_rtc_cq_offset = o_rtc_resp_valid ? r_offset : '0;
  assign ov_rrc_cq_offset = o_rrc_resp_valid ? r_offset : '0;
  assign ov_ee_cq_offset  = o_ee_resp_valid  ? r_offset : '0;

  assign o_cqm_req_valid  = (r_state == ST_ISSUE);
  assign ov_cqm_cq_index  = r_idx;
  assign ov_cqm_cq_size   = r_size;
  assign o_timeout_err    = r_err;
  assign o_busy           = (r_state != ST_IDLE);

endmodule

`default_nettype wire
